crc_encoder: RTL and testbench

CRC_ENCODER -- requirements
Module: crc_encoder

---
 rtl/crc_pkg.sv | 13 +
 rtl/crc4_lfsr_step.sv | 25 ++
 rtl/crc_encoder.sv | 111 +++++++++++
 tb/tb_crc_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC-4 constants and encoder FSM state type.
package crc_pkg;

    localparam int CRC_WIDTH = 4;
    localparam logic [CRC_WIDTH:0] CRC4_POLY = 5'b10011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/crc4_lfsr_step.sv
// One serial CRC-4 step: folds one message bit into the running remainder.
module crc4_lfsr_step
    import crc_pkg::*;
(
    input  logic [CRC_WIDTH-1:0] rem,
    input  logic                 data_bit,
    output logic [CRC_WIDTH-1:0] rem_next
);

    logic fb;

    assign fb = data_bit ^ rem[CRC_WIDTH-1];

    // Each remainder bit is its lower neighbour, XOR feedback where the generator has a tap.
    generate
        for (genvar gi = 0; gi < CRC_WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign rem_next[gi] = fb & CRC4_POLY[gi];
            end else begin : g_upper
                assign rem_next[gi] = rem[gi-1] ^ (fb & CRC4_POLY[gi]);
            end
        end
    endgenerate

endmodule

// File: rtl/crc_encoder.sv
// Serial CRC-4 (x^4+x+1) encoder producing {payload, crc}; one payload bit per cycle.
// Optional feature: define CRC_ENC_FRAME_CNT_EN to add a 16-bit frame_count output.
module crc_encoder
    import crc_pkg::*;
#(
    parameter int DATA_BITS   = 16,
    parameter int OUTPUT_BITS = DATA_BITS + 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_BITS-1:0]   InputData,
    output logic                   Busy,
    output logic                   Ready,
    output logic [OUTPUT_BITS-1:0] OutputData
`ifdef CRC_ENC_FRAME_CNT_EN
    ,
    output logic [15:0]            frame_count
`endif
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    state_t                 state_reg;
    state_t                 state_next;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_next;
    logic [CRC_WIDTH-1:0]   rem_reg;
    logic [CRC_WIDTH-1:0]   rem_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   start_last_reg;
    logic [OUTPUT_BITS-1:0] out_reg;
    logic                   launch;
    logic                   last_bit;
`ifdef CRC_ENC_FRAME_CNT_EN
    logic [15:0]            frame_cnt_reg;
`endif

    assign launch   = start & ~start_last_reg;
    assign last_bit = (cnt_reg == CNT_W'(DATA_BITS - 1));

    // The payload is rotated rather than shifted, so after DATA_BITS steps it is back
    // in its launch-time order and no separate copy is needed.
    assign shift_next = {shift_reg[DATA_BITS-2:0], shift_reg[DATA_BITS-1]};

    crc4_lfsr_step u_step (
        .rem      (rem_reg),
        .data_bit (shift_reg[DATA_BITS-1]),
        .rem_next (rem_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            rem_reg        <= '0;
            cnt_reg        <= '0;
            start_last_reg <= 1'b1;
            out_reg        <= '0;
`ifdef CRC_ENC_FRAME_CNT_EN
            frame_cnt_reg  <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            start_last_reg <= start;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        shift_reg <= InputData;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    rem_reg   <= rem_next;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        out_reg <= {shift_next, rem_next};
`ifdef CRC_ENC_FRAME_CNT_EN
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch)   state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    if (!start)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy       = (state_reg == SHIFT);
        Ready      = (state_reg == DONE);
        OutputData = out_reg;
    end

`ifdef CRC_ENC_FRAME_CNT_EN
    assign frame_count = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_crc_encoder.sv
// Self-checking bench for crc_encoder (DATA_BITS=16) using a polynomial-division reference.
module tb_crc_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] InputData;
    logic        Busy;
    logic        Ready;
    logic [19:0] OutputData;
`ifdef CRC_ENC_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    crc_encoder #(.DATA_BITS(16), .OUTPUT_BITS(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .InputData  (InputData),
        .Busy       (Busy),
        .Ready      (Ready),
        .OutputData (OutputData)
`ifdef CRC_ENC_FRAME_CNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs [5];

    // Remainder of a 20-bit polynomial modulo x^4+x+1 by long division.
    function automatic logic [3:0] poly_mod(input logic [19:0] v);
        logic [19:0] a;
        logic [19:0] g;
        a = v;
        g = 20'h00013;
        for (int i = 19; i >= 4; i--) begin
            if (a[i]) a = a ^ (g << (i - 4));
        end
        return a[3:0];
    endfunction

    function automatic logic [19:0] ref_codeword(input logic [15:0] d);
        return {d, poly_mod({d, 4'b0000})};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Launch an encode (start must be low beforehand) and wait for Ready.
    task automatic run_encode(input logic [15:0] d, input bit scramble, output logic [19:0] q);
        int   lat;
        logic seen;
        logic flags_ok;
        InputData = d;
        start     = 1'b1;
        lat       = 0;
        seen      = 1'b0;
        flags_ok  = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (Busy && Ready) flags_ok = 1'b0;
            if (Ready) seen = 1'b1;
            else if (!Busy) flags_ok = 1'b0;
            if (!seen && scramble) begin
                InputData = 16'($urandom);
                start     = 1'($urandom_range(0, 1));
            end
        end
        check("ready_latency", 64'(seen ? lat : -1), 64'd17);
        check("busy_in_shift_only", 64'(flags_ok), 64'd1);
        q = OutputData;
        $display("encode d=%04h q=%05h latency=%0d", d, q, lat);
    endtask

    task automatic release_start(input logic [19:0] q);
        start = 1'b0;
        @(negedge clk);
        check("ready_drops", 64'(Ready), 64'd0);
        check("output_holds_in_idle", 64'(OutputData), 64'(q));
    endtask

    initial begin
        logic [19:0] q;
        logic [15:0] d;
        logic        hold_ok;
        int          k;

        vecs[0] = '{16'h0001, 20'h00013};
        vecs[1] = '{16'h0000, 20'h00000};
        vecs[2] = '{16'h0002, 20'h00026};
        vecs[3] = '{16'h8000, 20'h80003};
        vecs[4] = '{16'hFFFF, 20'hFFFF3};

        // Reset with start already high: nothing may launch on release.
        rst       = 1'b1;
        start     = 1'b1;
        InputData = 16'hA5A5;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_ready", 64'(Ready), 64'd0);
        check("reset_output", 64'(OutputData), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_launch_after_reset", 64'(Busy), 64'd0);
        $display("reset released with start high, busy=%0b", Busy);
        start = 1'b0;
        @(negedge clk);

        // Fixed vectors.
        for (int i = 0; i < 5; i++) begin
            run_encode(vecs[i].d, 1'b0, q);
            check("vector_codeword", 64'(q), 64'(vecs[i].exp));
            release_start(q);
        end

        // Start held high in DONE: codeword and Ready hold, no new encode.
        run_encode(16'h1234, 1'b0, q);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!Ready || Busy || OutputData !== q) hold_ok = 1'b0;
        end
        check("done_holds_while_start_high", 64'(hold_ok), 64'd1);
        $display("held start in DONE for 10 cycles, q=%05h", OutputData);
        // One-cycle drop then raise: launches from the first IDLE cycle.
        start = 1'b0;
        @(negedge clk);
        check("idle_after_drop", 64'(Ready), 64'd0);
        run_encode(16'hBEEF, 1'b0, q);
        check("relaunch_codeword", 64'(q), 64'(ref_codeword(16'hBEEF)));
        release_start(q);

        // Reset during the 8th SHIFT cycle aborts with no partial output.
        InputData = 16'hC3C3;
        start     = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_ready", 64'(Ready), 64'd0);
        check("abort_output", 64'(OutputData), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_relaunch", 64'(Busy), 64'd0);
        $display("reset mid-shift, output=%05h busy=%0b", OutputData, Busy);
        start = 1'b0;
        @(negedge clk);

        // Inputs churning during SHIFT must not affect the codeword.
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom);
            run_encode(d, 1'b1, q);
            check("launch_value_only", 64'(q), 64'(ref_codeword(d)));
            release_start(q);
        end

        // Random payloads through the reference and a zero-remainder decoder check.
        for (int i = 0; i < 1000; i++) begin
            d = 16'($urandom);
            run_encode(d, 1'b0, q);
            check("random_codeword", 64'(q), 64'(ref_codeword(d)));
            check("decode_valid", 64'(poly_mod(q) == 4'h0), 64'd1);
            k = int'($urandom_range(0, 19));
            check("decode_flip_invalid", 64'(poly_mod(q ^ (20'h1 << k)) != 4'h0), 64'd1);
            release_start(q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
